// File: rtl/sram_dp_mc_if.sv
// One port of the multi-channel dual-port SRAM.
// Lane k of each packed vector sits at [W*(k+1)-1 -: W].
interface sram_dp_mc_if #(
    parameter int DATA_WIDTH         = 8,
    parameter int ADDRW              = 12,
    parameter int MAX_CHANNELS       = 64,
    parameter int NUM_CHANNELS_WIDTH = $clog2(MAX_CHANNELS + 1)
);
    logic                               en_i;
    logic                               we_i;
    logic [NUM_CHANNELS_WIDTH-1:0]      num_channels_i;
    logic [ADDRW*MAX_CHANNELS-1:0]      addr_i;
    logic [DATA_WIDTH*MAX_CHANNELS-1:0] data_i;
    logic [DATA_WIDTH*MAX_CHANNELS-1:0] data_o;
    logic                               ready_o;

    modport master (
        output en_i, we_i, num_channels_i, addr_i, data_i,
        input  data_o, ready_o
    );

    modport slave (
        input  en_i, we_i, num_channels_i, addr_i, data_i,
        output data_o, ready_o
    );
endinterface

// File: rtl/sram_dp_mc.sv
// Dual-port, multi-lane SRAM: each port moves up to MAX_CHANNELS scattered words
// per cycle. Reads are read-first with one cycle of latency and a ready pulse.
module sram_dp_mc #(
    parameter int DATA_WIDTH         = 8,
    parameter int N_ENTRIES          = 4096,
    parameter int ADDRW              = $clog2(N_ENTRIES),
    parameter int MAX_CHANNELS       = 64,
    parameter int NUM_CHANNELS_WIDTH = $clog2(MAX_CHANNELS + 1)
) (
    input logic         clk_i,
    input logic         rst_i,
    sram_dp_mc_if.slave port1,
    sram_dp_mc_if.slave port2
);
    localparam int LANES_W = DATA_WIDTH * MAX_CHANNELS;

    logic [DATA_WIDTH-1:0] r_mem [N_ENTRIES];
    logic [LANES_W-1:0]    r_data1;
    logic [LANES_W-1:0]    r_data2;
    logic                  r_ready1;
    logic                  r_ready2;

    logic w_wr1;
    logic w_wr2;
    logic w_rd1;
    logic w_rd2;

    assign w_wr1 = port1.en_i &  port1.we_i;
    assign w_wr2 = port2.en_i &  port2.we_i;
    assign w_rd1 = port1.en_i & ~port1.we_i;
    assign w_rd2 = port2.en_i & ~port2.we_i;

    // Any count above MAX_CHANNELS activates every lane, which is the clamp.
    function automatic logic lane_hit(input int k,
                                      input logic [NUM_CHANNELS_WIDTH-1:0] n,
                                      input logic [ADDRW-1:0] a);
        return (k < int'(n)) && (int'(a) < N_ENTRIES);
    endfunction

    function automatic logic [LANES_W-1:0] gather(input logic [ADDRW*MAX_CHANNELS-1:0] addr,
                                                  input logic [NUM_CHANNELS_WIDTH-1:0] n);
        logic [LANES_W-1:0] v;
        v = '0;
        for (int k = 0; k < MAX_CHANNELS; k++) begin
            if (lane_hit(k, n, addr[ADDRW*k +: ADDRW]))
                v[DATA_WIDTH*k +: DATA_WIDTH] = r_mem[addr[ADDRW*k +: ADDRW]];
        end
        return v;
    endfunction

    // NOTE: the array is deliberately left out of reset so it maps onto SRAM;
    // only the output registers are cleared.
    // Port 2 is scanned after port 1 and lanes in ascending order, so the last
    // non-blocking update wins: port 2 over port 1, high lane over low lane.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int k = 0; k < MAX_CHANNELS; k++) begin
                if (w_wr1 && lane_hit(k, port1.num_channels_i, port1.addr_i[ADDRW*k +: ADDRW]))
                    r_mem[port1.addr_i[ADDRW*k +: ADDRW]] <= port1.data_i[DATA_WIDTH*k +: DATA_WIDTH];
            end
            for (int k = 0; k < MAX_CHANNELS; k++) begin
                if (w_wr2 && lane_hit(k, port2.num_channels_i, port2.addr_i[ADDRW*k +: ADDRW]))
                    r_mem[port2.addr_i[ADDRW*k +: ADDRW]] <= port2.data_i[DATA_WIDTH*k +: DATA_WIDTH];
            end
        end
    end

    // NOTE: non-blocking updates mean reads in this edge see pre-write contents,
    // which is exactly the read-first behaviour both ports rely on.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data1  <= '0;
            r_ready1 <= 1'b0;
        end else if (w_rd1) begin
            r_data1  <= gather(port1.addr_i, port1.num_channels_i);
            r_ready1 <= 1'b1;
        end else begin
            r_ready1 <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data2  <= '0;
            r_ready2 <= 1'b0;
        end else if (w_rd2) begin
            r_data2  <= gather(port2.addr_i, port2.num_channels_i);
            r_ready2 <= 1'b1;
        end else begin
            r_ready2 <= 1'b0;
        end
    end

    assign port1.data_o  = r_data1;
    assign port1.ready_o = r_ready1;
    assign port2.data_o  = r_data2;
    assign port2.ready_o = r_ready2;
endmodule

// File: tb/tb_sram_dp_mc.sv
// Bench for sram_dp_mc: randomized lane traffic scored against an array model
// that applies the read-first, lane-order and port-order rules directly.
module tb_sram_dp_mc;
    localparam int DW  = 8;
    localparam int NE  = 4096;
    localparam int AW  = 12;
    localparam int MC  = 64;
    localparam int NCW = 7;
    localparam int LW  = DW * MC;
    localparam int AL  = AW * MC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_dp_mc_if #(.DATA_WIDTH(DW), .ADDRW(AW), .MAX_CHANNELS(MC), .NUM_CHANNELS_WIDTH(NCW)) p1 ();
    sram_dp_mc_if #(.DATA_WIDTH(DW), .ADDRW(AW), .MAX_CHANNELS(MC), .NUM_CHANNELS_WIDTH(NCW)) p2 ();

    sram_dp_mc #(.DATA_WIDTH(DW), .N_ENTRIES(NE), .ADDRW(AW), .MAX_CHANNELS(MC),
                 .NUM_CHANNELS_WIDTH(NCW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .port1 (p1),
        .port2 (p2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mem_m [NE];
    logic [LW-1:0] exp_d1 = '0;
    logic [LW-1:0] exp_d2 = '0;
    logic          exp_r1 = 1'b0;
    logic          exp_r2 = 1'b0;

    function automatic logic [LW-1:0] model_read(input logic [AL-1:0] addr, input int nc);
        logic [LW-1:0] r;
        int n;
        r = '0;
        n = (nc > MC) ? MC : nc;
        for (int k = 0; k < n; k++) r[DW*k +: DW] = mem_m[addr[AW*k +: AW]];
        return r;
    endfunction

    task automatic model_write(input logic [AL-1:0] addr, input logic [LW-1:0] data, input int nc);
        int n;
        n = (nc > MC) ? MC : nc;
        for (int k = 0; k < n; k++) mem_m[addr[AW*k +: AW]] = data[DW*k +: DW];
    endtask

    function automatic logic [AL-1:0] rand_addrs(input int lo, input int hi);
        logic [AL-1:0] v;
        for (int k = 0; k < MC; k++) v[AW*k +: AW] = AW'($urandom_range(hi, lo));
        return v;
    endfunction

    function automatic logic [LW-1:0] rand_data();
        logic [LW-1:0] v;
        for (int k = 0; k < MC; k++) v[DW*k +: DW] = DW'($urandom);
        return v;
    endfunction

    task automatic drive(input int port, input logic en, input logic we, input int nc,
                         input logic [AL-1:0] a, input logic [LW-1:0] d);
        if (port == 1) begin
            p1.en_i = en; p1.we_i = we; p1.num_channels_i = NCW'(nc); p1.addr_i = a; p1.data_i = d;
        end else begin
            p2.en_i = en; p2.we_i = we; p2.num_channels_i = NCW'(nc); p2.addr_i = a; p2.data_i = d;
        end
    endtask

    task automatic idle(input int port);
        drive(port, 1'b0, 1'b0, 0, '0, '0);
    endtask

    // Advance one edge: expectations come from the model state before the edge.
    task automatic step();
        if (rst) begin
            exp_r1 = 1'b0; exp_r2 = 1'b0; exp_d1 = '0; exp_d2 = '0;
        end else begin
            exp_r1 = p1.en_i && !p1.we_i;
            exp_r2 = p2.en_i && !p2.we_i;
            if (exp_r1) exp_d1 = model_read(p1.addr_i, int'(p1.num_channels_i));
            if (exp_r2) exp_d2 = model_read(p2.addr_i, int'(p2.num_channels_i));
            if (p1.en_i && p1.we_i) model_write(p1.addr_i, p1.data_i, int'(p1.num_channels_i));
            if (p2.en_i && p2.we_i) model_write(p2.addr_i, p2.data_i, int'(p2.num_channels_i));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 1'b1, 1'b1, MC, rand_addrs(0, NE-1), rand_data());
        drive(2, 1'b1, 1'b0, MC, rand_addrs(0, NE-1), '0);
        step();
        n_checks++; if (p1.ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready1: got %b expected 0", p1.ready_o); end
        n_checks++; if (p2.ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready2: got %b expected 0", p2.ready_o); end
        n_checks++; if (p1.data_o !== '0) begin n_fail++; $display("FAIL reset_data1: got %h expected 0", p1.data_o); end
        n_checks++; if (p2.data_o !== '0) begin n_fail++; $display("FAIL reset_data2: got %h expected 0", p2.data_o); end
        rst = 1'b0;
        idle(1); idle(2);
    endtask

    task automatic test_lane_sweep();
        logic [AL-1:0] a;
        for (int n = 1; n <= MC; n++) begin
            a = rand_addrs(0, NE-1);
            for (int k = 0; k < n; k++) a[AW*k +: AW] = AW'(k);
            drive(1, 1'b1, 1'b1, n, a, rand_data());
            idle(2);
            step();
            a = rand_addrs(0, NE-1);
            for (int k = 0; k < n; k++) a[AW*k +: AW] = AW'(k);
            idle(1);
            drive(2, 1'b1, 1'b0, n, a, rand_data());
            step();
            n_checks++; if (p2.ready_o !== 1'b1) begin n_fail++; $display("FAIL sweep_ready n=%0d: got %b expected 1", n, p2.ready_o); end
            n_checks++; if (p2.data_o !== exp_d2) begin n_fail++; $display("FAIL sweep_data n=%0d: got %h expected %h", n, p2.data_o, exp_d2); end
        end
        idle(2);
    endtask

    task automatic test_read_first();
        logic [AL-1:0] a;
        logic [LW-1:0] d;
        a = '0; a[AW-1:0] = AW'(5);
        d = '0; d[DW-1:0] = 8'h11;
        drive(1, 1'b1, 1'b1, 1, a, d); idle(2);
        step();
        d[DW-1:0] = 8'h22;
        drive(1, 1'b1, 1'b1, 1, a, d);
        drive(2, 1'b1, 1'b0, 1, a, '0);
        step();
        n_checks++; if (p2.data_o[DW-1:0] !== 8'h11) begin n_fail++; $display("FAIL read_first_old: got %h expected 11", p2.data_o[DW-1:0]); end
        d[DW-1:0] = 8'h33;
        drive(1, 1'b1, 1'b0, 1, a, '0);
        drive(2, 1'b1, 1'b1, 1, a, d);
        step();
        n_checks++; if (p1.data_o[DW-1:0] !== 8'h22) begin n_fail++; $display("FAIL read_first_new: got %h expected 22", p1.data_o[DW-1:0]); end
        idle(1);
        drive(2, 1'b1, 1'b0, 1, a, '0);
        step();
        n_checks++; if (p2.data_o !== exp_d2) begin n_fail++; $display("FAIL read_first_p2w: got %h expected %h", p2.data_o, exp_d2); end
        idle(2);
    endtask

    task automatic test_write_conflict();
        logic [AL-1:0] a;
        logic [LW-1:0] d;
        logic [LW-1:0] e;
        a = '0; d = '0;
        a[AW*0 +: AW] = AW'(7);   d[DW*0 +: DW] = 8'h01;
        a[AW*1 +: AW] = AW'(100); d[DW*1 +: DW] = 8'hAA;
        a[AW*2 +: AW] = AW'(8);   d[DW*2 +: DW] = 8'h02;
        a[AW*3 +: AW] = AW'(7);   d[DW*3 +: DW] = 8'h04;
        drive(1, 1'b1, 1'b1, 4, a, d);
        a = '0; d = '0;
        a[AW-1:0] = AW'(100); d[DW-1:0] = 8'hBB;
        drive(2, 1'b1, 1'b1, 1, a, d);
        step();
        a = '0;
        a[AW*0 +: AW] = AW'(100);
        a[AW*1 +: AW] = AW'(7);
        drive(1, 1'b1, 1'b0, 2, a, '0); idle(2);
        step();
        e = '0; e[DW*0 +: DW] = 8'hBB; e[DW*1 +: DW] = 8'h04;
        n_checks++; if (p1.data_o !== e) begin n_fail++; $display("FAIL write_conflict: got %h expected %h", p1.data_o, e); end
        n_checks++; if (p1.ready_o !== 1'b1) begin n_fail++; $display("FAIL write_conflict_ready: got %b expected 1", p1.ready_o); end
        idle(1);
    endtask

    task automatic test_clamp_zero();
        logic [AL-1:0] a;
        logic [LW-1:0] d;
        drive(2, 1'b1, 1'b0, 0, rand_addrs(0, NE-1), '0); idle(1);
        step();
        n_checks++; if (p2.ready_o !== 1'b1) begin n_fail++; $display("FAIL zero_read_ready: got %b expected 1", p2.ready_o); end
        n_checks++; if (p2.data_o !== '0) begin n_fail++; $display("FAIL zero_read_data: got %h expected 0", p2.data_o); end
        a = rand_addrs(0, 63);
        drive(1, 1'b1, 1'b1, 0, a, rand_data()); idle(2);
        step();
        drive(1, 1'b1, 1'b0, MC, a, '0);
        step();
        n_checks++; if (p1.data_o !== exp_d1) begin n_fail++; $display("FAIL zero_write_noop: got %h expected %h", p1.data_o, exp_d1); end
        for (int k = 0; k < MC; k++) a[AW*k +: AW] = AW'(NE - MC + k);
        d = rand_data();
        drive(1, 1'b1, 1'b1, 127, a, d);
        step();
        for (int k = 0; k < MC; k++) a[AW*k +: AW] = AW'(NE - 1 - k);
        idle(1);
        drive(2, 1'b1, 1'b0, MC, a, '0);
        step();
        n_checks++; if (p2.data_o !== exp_d2) begin n_fail++; $display("FAIL clamp_full: got %h expected %h", p2.data_o, exp_d2); end
        n_checks++; if (p2.data_o[DW-1:0] !== d[LW-1 -: DW]) begin n_fail++; $display("FAIL lane63_4095: got %h expected %h", p2.data_o[DW-1:0], d[LW-1 -: DW]); end
        drive(2, 1'b1, 1'b0, 100, rand_addrs(0, 63), '0);
        step();
        n_checks++; if (p2.data_o !== exp_d2) begin n_fail++; $display("FAIL clamp_100: got %h expected %h", p2.data_o, exp_d2); end
        idle(2);
    endtask

    task automatic test_reset_midread();
        logic [AL-1:0] a;
        logic [LW-1:0] d;
        a = '0; a[AW*0 +: AW] = AW'(100); a[AW*1 +: AW] = AW'(7);
        drive(2, 1'b1, 1'b0, 2, a, '0); idle(1);
        step();
        n_checks++; if (p2.ready_o !== 1'b1) begin n_fail++; $display("FAIL pre_reset_ready: got %b expected 1", p2.ready_o); end
        rst = 1'b1;
        d = '0; d[DW-1:0] = 8'h5A;
        drive(1, 1'b1, 1'b1, 1, {a[AL-1:AW], AW'(7)}, d);
        step();
        n_checks++; if (p2.ready_o !== 1'b0) begin n_fail++; $display("FAIL midread_ready: got %b expected 0", p2.ready_o); end
        n_checks++; if (p2.data_o !== '0) begin n_fail++; $display("FAIL midread_data: got %h expected 0", p2.data_o); end
        rst = 1'b0;
        idle(1);
        step();
        step();
        n_checks++; if (p2.data_o !== exp_d2 || exp_d2[DW +: DW] !== 8'h04) begin n_fail++; $display("FAIL post_reset_mem: got %h expected %h", p2.data_o, exp_d2); end
        idle(2);
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 4; c++) begin
            drive(2, 1'b1, 1'b0, 8, rand_addrs(0, 63), '0);
            drive(1, 1'b1, 1'b1, $urandom_range(8, 0), rand_addrs(0, 63), rand_data());
            step();
            n_checks++; if (p2.ready_o !== 1'b1) begin n_fail++; $display("FAIL stream_ready c=%0d: got %b expected 1", c, p2.ready_o); end
            n_checks++; if (p2.data_o !== exp_d2) begin n_fail++; $display("FAIL stream_data c=%0d: got %h expected %h", c, p2.data_o, exp_d2); end
        end
        idle(1); idle(2);
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            rst = ($urandom_range(19, 0) == 0);
            drive(1, 1'($urandom), 1'($urandom), $urandom_range(80, 0), rand_addrs(0, 63), rand_data());
            drive(2, 1'($urandom), 1'($urandom), $urandom_range(80, 0), rand_addrs(0, 63), rand_data());
            step();
            n_checks++; if (p1.ready_o !== exp_r1) begin n_fail++; $display("FAIL rand_ready1 c=%0d: got %b expected %b", c, p1.ready_o, exp_r1); end
            n_checks++; if (p2.ready_o !== exp_r2) begin n_fail++; $display("FAIL rand_ready2 c=%0d: got %b expected %b", c, p2.ready_o, exp_r2); end
            n_checks++; if (p1.data_o !== exp_d1) begin n_fail++; $display("FAIL rand_data1 c=%0d: got %h expected %h", c, p1.data_o, exp_d1); end
            n_checks++; if (p2.data_o !== exp_d2) begin n_fail++; $display("FAIL rand_data2 c=%0d: got %h expected %h", c, p2.data_o, exp_d2); end
        end
        rst = 1'b0;
        idle(1); idle(2);
    endtask

    initial begin
        idle(1); idle(2);
        test_reset();
        test_lane_sweep();
        test_read_first();
        test_write_conflict();
        test_clamp_zero();
        test_reset_midread();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_dp_mc.md
# sram_dp_mc

Multi-channel dual-port on-chip SRAM for the NPU data path: a single array of `N_ENTRIES` × `DATA_WIDTH` words reachable from two independent ports. Each port carries up to `MAX_CHANNELS` address/data lanes per access, gated by a per-access active-lane count, so a vector of scattered bytes is read or written in one cycle. Both ports share one clock. Reads return registered data with a one-cycle ready pulse.

## Interface
- `DATA_WIDTH`, 8: bits per word/lane.
- `N_ENTRIES`, 4096: words in the array.
- `ADDRW`, $clog2(N_ENTRIES): bits per lane address.
- `MAX_CHANNELS`, 64: lanes per port.
- `NUM_CHANNELS_WIDTH`, $clog2(MAX_CHANNELS+1): width of the lane-count inputs.

Ports:
- `clk_i` in 1: single clock for both ports; all logic on the rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `en1_i` / `en2_i` in 1: port access enable.
- `we1_i` / `we2_i` in 1: 1 = write, 0 = read (only when enabled).
- `num_channels1_i` / `num_channels2_i` in NUM_CHANNELS_WIDTH: active lanes; lanes 0..n-1 are active.
- `addr1_i` / `addr2_i` in ADDRW*MAX_CHANNELS: lane k address at bits [ADDRW*(k+1)-1 -: ADDRW].
- `data1_i` / `data2_i` in DATA_WIDTH*MAX_CHANNELS: lane k write data at bits [DATA_WIDTH*(k+1)-1 -: DATA_WIDTH].
- `data1_o` / `data2_o` out DATA_WIDTH*MAX_CHANNELS: registered read data, same lane packing.
- `ready1_o` / `ready2_o` out 1: read data valid.

## Operation
- Effective lane count n = min(num_channels, MAX_CHANNELS). Lanes ≥ n are ignored.
- **Write** (`en=1`, `we=1`): at the edge, each active lane k stores its data at its address. Write data is not echoed to `data_o`.
- **Duplicate addresses within one port's write:** the highest-numbered lane wins.
- **Both ports write the same address in the same cycle:** port 2 wins.
- **Read** (`en=1`, `we=0`): at the edge, each active lane k registers mem[addr_k] into `data_o` lane k. Inactive lanes register 0.
- **Read-during-write** to the same address, from either port, is read-first: the read returns the value stored before that edge.
- **Out-of-range address** (≥ N_ENTRIES, non-power-of-two case): the write is dropped and the read returns 0.
- **n = 0 read:** `ready` still pulses and `data_o` is all zero.
- **n = 0 write:** no-op.
- **No access** (`en=0`, or write): `ready_o` goes to 0 at the next edge. `data_o` holds its last value.
- **Memory contents:** not reset, X until written. Only the output registers reset.
- **Reset:** `rst_i` has priority over everything; accesses presented while `rst_i=1` (including writes) are ignored.

## Timing
- Write latency: data is readable by any port from the edge after the write edge (a read issued in the same edge sees old data).
- Read latency: 1 cycle. A read sampled at edge T drives `data_o`/`ready_o` valid after T, through to edge T+1.
- Back-to-back reads with `en` held high: `ready_o` stays 1 and `data_o` updates every cycle.
- No backpressure. `ready_o` is a status flag, not a handshake; the requester must capture data in the cycle `ready_o=1`.
- The two ports are fully independent. Simultaneous read on one port and write on the other is allowed every cycle.
- Reset values: `data1_o = data2_o = 0`, `ready1_o = ready2_o = 0`, applied at the first edge with `rst_i=1`. Reset mid-read clears a pending ready/data on that edge.

## Test plan
- **Lane sweep:** for n = 1..64, port 1 writes random bytes to addresses 0..n-1, then port 2 reads addresses 0..n-1. Required: `ready2_o=1` one cycle later, and every lane < n matches the written byte; lanes ≥ n read 0.
- **Read-first collision:** mem[5]=0x11 already stored. In the same cycle, port 1 writes 0x22 to address 5 and port 2 reads address 5. Required: read returns 0x11; a read next cycle returns 0x22.
- **Write-write conflict:** port 1 writes 0xAA and port 2 writes 0xBB to address 100 in the same cycle. Also, port 1 lanes 0 and 3 both target address 7 with 0x01 and 0x04. Required: mem[100]=0xBB, mem[7]=0x04.
- **Clamp and zero count:** num_channels = 0 on a read gives `ready=1` and all-zero data. num_channels = 64 with lane 63 at address 4095 round-trips correctly.
- **Reset:** assert `rst_i` during a read cycle. Required: the next edge shows `ready_o=0` and `data_o=0`, previously written memory is still readable after reset, and a write issued during reset is not stored.
- **Streaming reads:** hold `en2_i=1` and `we2_i=0` for 4 cycles with changing addresses. Required: `ready2_o` stays high, with data updating each cycle at 1-cycle latency.
